ls_issue_queue: RTL and testbench

- In-order issue queue for load/store instructions, directly upstream of the load/store unit.
- Buffers decoded memory instructions from dispatch with their ROB slot.
- Captures missing A (base) and B (store data) operands from the ROB writeback broadcast.
- Presents the oldest instruction to the LS unit once both operands are available; the LS unit consumes it when its ready is high.

---
 rtl/ls_issue_queue.sv | 191 +++++++++++++++++++
 tb/tb_ls_issue_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: buffers dispatched memory ops, captures missing
// operands from the ROB writeback broadcast, and presents the oldest op to the LS unit.

package ls_iq_pkg;
    typedef struct packed {
        logic        is_store;
        logic [1:0]  size;
        logic        sign_ext;
        logic [11:0] imm;
    } dec_inst_t;
endpackage

module ls_iq_entry
    import ls_iq_pkg::*;
#(
    parameter int ROB_DEPTHLOG2 = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic                     clr,
    input  dec_inst_t                wr_inst,
    input  logic [ROB_DEPTHLOG2-1:0] wr_rob_slot,
    input  logic [31:0]              wr_a,
    input  logic                     wr_a_rdy,
    input  logic [ROB_DEPTHLOG2-1:0] wr_a_tag,
    input  logic [31:0]              wr_b,
    input  logic                     wr_b_rdy,
    input  logic [ROB_DEPTHLOG2-1:0] wr_b_tag,
    input  logic                     wb_valid,
    input  logic [ROB_DEPTHLOG2-1:0] wb_idx,
    input  logic [31:0]              wb_data,
    output logic                     valid,
    output dec_inst_t                inst,
    output logic [ROB_DEPTHLOG2-1:0] rob_slot,
    output logic [31:0]              a,
    output logic                     a_rdy,
    output logic [31:0]              b,
    output logic                     b_rdy
);
    logic [ROB_DEPTHLOG2-1:0] a_tag, b_tag;
    logic                     a_wake, b_wake;

    assign a_wake = valid & ~a_rdy & wb_valid & (a_tag == wb_idx);
    assign b_wake = valid & ~b_rdy & wb_valid & (b_tag == wb_idx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            inst     <= '0;
            rob_slot <= '0;
            a        <= '0;
            a_rdy    <= 1'b0;
            a_tag    <= '0;
            b        <= '0;
            b_rdy    <= 1'b0;
            b_tag    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid    <= 1'b1;
            inst     <= wr_inst;
            rob_slot <= wr_rob_slot;
            a        <= wr_a;
            a_rdy    <= wr_a_rdy;
            a_tag    <= wr_a_tag;
            b        <= wr_b;
            b_rdy    <= wr_b_rdy;
            b_tag    <= wr_b_tag;
        end else begin
            if (clr) valid <= 1'b0;
            if (a_wake) begin
                a     <= wb_data;
                a_rdy <= 1'b1;
            end
            if (b_wake) begin
                b     <= wb_data;
                b_rdy <= 1'b1;
            end
        end
    end
endmodule

module ls_issue_queue
    import ls_iq_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int ROB_DEPTHLOG2 = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enq_valid,
    input  dec_inst_t                  enq_inst,
    input  logic [ROB_DEPTHLOG2-1:0]   enq_rob_slot,
    input  logic [31:0]                enq_A,
    input  logic [31:0]                enq_B,
    input  logic                       enq_A_rdy,
    input  logic                       enq_B_rdy,
    input  logic [ROB_DEPTHLOG2-1:0]   enq_A_tag,
    input  logic [ROB_DEPTHLOG2-1:0]   enq_B_tag,
    output logic                       enq_ready,
    input  logic                       wb_valid,
    input  logic [ROB_DEPTHLOG2-1:0]   wb_idx,
    input  logic [31:0]                wb_data,
    input  logic                       flush,
    output dec_inst_t                  inst,
    output logic                       inst_valid,
    output logic [31:0]                A,
    output logic [31:0]                B,
    output logic [ROB_DEPTHLOG2-1:0]   rob_slot,
    input  logic                       ls_ready,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]                    head, tail;
    logic [DEPTH-1:0]                    e_valid, e_a_rdy, e_b_rdy;
    dec_inst_t                           e_inst [DEPTH];
    logic [DEPTH-1:0][ROB_DEPTHLOG2-1:0] e_slot;
    logic [DEPTH-1:0][31:0]              e_a, e_b;
    logic                                do_enq, do_deq;
    logic                                cap_a, cap_b;
    logic [31:0]                         wr_a, wr_b;

    assign enq_ready  = (count != FULL);
    assign do_enq     = enq_valid & enq_ready;
    assign inst_valid = e_valid[head] & e_a_rdy[head] & e_b_rdy[head];
    assign do_deq     = inst_valid & ls_ready;

    assign inst     = e_inst[head];
    assign rob_slot = e_slot[head];
    assign A        = e_a[head];
    assign B        = e_b[head];

    // Operand being broadcast in the enqueue cycle is captured directly into the new entry.
    assign cap_a = wb_valid & ~enq_A_rdy & (enq_A_tag == wb_idx);
    assign cap_b = wb_valid & ~enq_B_rdy & (enq_B_tag == wb_idx);
    assign wr_a  = cap_a ? wb_data : enq_A;
    assign wr_b  = cap_b ? wb_data : enq_B;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        ls_iq_entry #(.ROB_DEPTHLOG2(ROB_DEPTHLOG2)) u_ent (
            .clock       (clock),
            .reset       (reset),
            .flush       (flush),
            .wr_en       (do_enq && (tail == PTR_W'(i))),
            .clr         (do_deq && (head == PTR_W'(i))),
            .wr_inst     (enq_inst),
            .wr_rob_slot (enq_rob_slot),
            .wr_a        (wr_a),
            .wr_a_rdy    (enq_A_rdy | cap_a),
            .wr_a_tag    (enq_A_tag),
            .wr_b        (wr_b),
            .wr_b_rdy    (enq_B_rdy | cap_b),
            .wr_b_tag    (enq_B_tag),
            .wb_valid    (wb_valid),
            .wb_idx      (wb_idx),
            .wb_data     (wb_data),
            .valid       (e_valid[i]),
            .inst        (e_inst[i]),
            .rob_slot    (e_slot[i]),
            .a           (e_a[i]),
            .a_rdy       (e_a_rdy[i]),
            .b           (e_b[i]),
            .b_rdy       (e_b_rdy[i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) tail <= tail + PTR_W'(1);
            if (do_deq) head <= head + PTR_W'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_ls_issue_queue.sv
// Scoreboard bench for ls_issue_queue: expected issues are queued at enqueue time
// and compared in order whenever the LS handshake fires.

module tb_ls_issue_queue;
    import ls_iq_pkg::*;

    localparam int DEPTH = 4;
    localparam int RW    = 4;

    typedef struct packed {
        dec_inst_t      inst;
        logic [RW-1:0]  slot;
        logic [31:0]    a;
        logic [31:0]    b;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            enq_valid = 1'b0;
    dec_inst_t       enq_inst = '0;
    logic [RW-1:0]   enq_rob_slot = '0;
    logic [31:0]     enq_A = '0, enq_B = '0;
    logic            enq_A_rdy = 1'b0, enq_B_rdy = 1'b0;
    logic [RW-1:0]   enq_A_tag = '0, enq_B_tag = '0;
    logic            enq_ready;
    logic            wb_valid = 1'b0;
    logic [RW-1:0]   wb_idx = '0;
    logic [31:0]     wb_data = '0;
    logic            flush = 1'b0;
    dec_inst_t       inst;
    logic            inst_valid;
    logic [31:0]     A, B;
    logic [RW-1:0]   rob_slot;
    logic            ls_ready = 1'b0;
    logic [2:0]      count;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    ls_issue_queue #(.DEPTH(DEPTH), .ROB_DEPTHLOG2(RW)) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_rob_slot(enq_rob_slot),
        .enq_A(enq_A), .enq_B(enq_B), .enq_A_rdy(enq_A_rdy), .enq_B_rdy(enq_B_rdy),
        .enq_A_tag(enq_A_tag), .enq_B_tag(enq_B_tag), .enq_ready(enq_ready),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data), .flush(flush),
        .inst(inst), .inst_valid(inst_valid), .A(A), .B(B), .rob_slot(rob_slot),
        .ls_ready(ls_ready), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_enq(input logic [15:0] iw, input logic [RW-1:0] slot,
                           input logic [31:0] a, input logic ardy, input logic [RW-1:0] atag,
                           input logic [31:0] b, input logic brdy, input logic [RW-1:0] btag);
        enq_valid    = 1'b1;
        enq_inst     = dec_inst_t'(iw);
        enq_rob_slot = slot;
        enq_A = a; enq_A_rdy = ardy; enq_A_tag = atag;
        enq_B = b; enq_B_rdy = brdy; enq_B_tag = btag;
    endtask

    function automatic exp_t mk(input logic [15:0] iw, input logic [RW-1:0] slot,
                                input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.inst = dec_inst_t'(iw);
        e.slot = slot;
        e.a    = a;
        e.b    = b;
        return e;
    endfunction

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && count != 0; i++) tick();
        chk({tag, "_cnt"}, 64'(count), 64'd0);
        chk({tag, "_sb"}, 64'(sb.size()), 64'd0);
    endtask

    // Handshake observed mid-cycle; inputs are only changed just after the rising edge.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && inst_valid && ls_ready) begin
            if (sb.size() == 0) chk("spurious_issue", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("iss_inst", 64'(inst), 64'(e.inst));
                chk("iss_slot", 64'(rob_slot), 64'(e.slot));
                chk("iss_A", 64'(A), 64'(e.a));
                chk("iss_B", 64'(B), 64'(e.b));
            end
        end
    end

    initial begin
        int mcnt, k;
        logic acc, deq;

        #1 reset = 1'b1;
        #3;
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        tick();

        // Simple load, one-cycle issue latency
        ls_ready = 1'b1;
        set_enq(16'h0004, 4'd3, 32'h100, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0);
        sb.push_back(mk(16'h0004, 4'd3, 32'h100, 32'h0));
        tick(); enq_valid = 1'b0;
        chk("ld_valid", 64'(inst_valid), 64'd1);
        chk("ld_A", 64'(A), 64'h100);
        chk("ld_slot", 64'(rob_slot), 64'd3);
        tick();
        chk("ld_count0", 64'(count), 64'd0);

        // Store waiting on B via writeback; unrelated tag must not wake it
        set_enq(16'h8008, 4'd6, 32'h200, 1'b1, 4'd0, 32'h0, 1'b0, 4'd5);
        sb.push_back(mk(16'h8008, 4'd6, 32'h200, 32'hDEADBEEF));
        tick(); enq_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_valid = (i == 1); wb_idx = 4'd6; wb_data = 32'h12345678;
            chk("st_wait", 64'(inst_valid), 64'd0);
            tick();
        end
        wb_valid = 1'b1; wb_idx = 4'd5; wb_data = 32'hDEADBEEF;
        tick(); wb_valid = 1'b0;
        chk("st_wake_valid", 64'(inst_valid), 64'd1);
        chk("st_wake_B", 64'(B), 64'hDEADBEEF);
        tick();

        // Enqueue-time capture
        set_enq(16'h0010, 4'd8, 32'h0, 1'b0, 4'd7, 32'h55, 1'b1, 4'd0);
        wb_valid = 1'b1; wb_idx = 4'd7; wb_data = 32'h40;
        sb.push_back(mk(16'h0010, 4'd8, 32'h40, 32'h55));
        tick(); enq_valid = 1'b0; wb_valid = 1'b0;
        chk("cap_valid", 64'(inst_valid), 64'd1);
        chk("cap_A", 64'(A), 64'h40);
        tick();

        // Fill to full, ignored 5th, then continuous traffic across the wrap
        ls_ready = 1'b0;
        for (k = 0; k < DEPTH; k++) begin
            set_enq(16'h0100 + 16'(k), 4'(k), 32'h1000 + k, 1'b1, 4'd0, 32'h2000 + k, 1'b1, 4'd0);
            sb.push_back(mk(16'h0100 + 16'(k), 4'(k), 32'h1000 + k, 32'h2000 + k));
            tick();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_enq_ready", 64'(enq_ready), 64'd0);
        set_enq(16'h0BAD, 4'hF, 32'hBAD, 1'b1, 4'd0, 32'hBAD, 1'b1, 4'd0);
        tick();
        chk("full_ignored", 64'(count), 64'd4);
        ls_ready = 1'b1;
        mcnt = DEPTH;
        for (int c = 0; c < 6; c++, k++) begin
            set_enq(16'h0100 + 16'(k), 4'(k), 32'h1000 + k, 1'b1, 4'd0, 32'h2000 + k, 1'b1, 4'd0);
            acc = (mcnt != DEPTH);
            deq = (mcnt != 0);
            if (acc) sb.push_back(mk(16'h0100 + 16'(k), 4'(k), 32'h1000 + k, 32'h2000 + k));
            mcnt = mcnt + int'(acc) - int'(deq);
            tick();
            chk("wrap_count", 64'(count), 64'(mcnt));
        end
        enq_valid = 1'b0;
        drain("wrap_drain");

        // Blocked head keeps a ready younger entry waiting; one broadcast wakes two entries
        set_enq(16'h0200, 4'd1, 32'h0, 1'b0, 4'd9, 32'h11, 1'b1, 4'd0);
        sb.push_back(mk(16'h0200, 4'd1, 32'h99, 32'h11));
        tick();
        set_enq(16'h0201, 4'd2, 32'h22, 1'b1, 4'd0, 32'h33, 1'b1, 4'd0);
        sb.push_back(mk(16'h0201, 4'd2, 32'h22, 32'h33));
        tick();
        set_enq(16'h8202, 4'd4, 32'h44, 1'b1, 4'd0, 32'h0, 1'b0, 4'd9);
        sb.push_back(mk(16'h8202, 4'd4, 32'h44, 32'h99));
        tick(); enq_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("ord_blocked", 64'(inst_valid), 64'd0);
            chk("ord_count", 64'(count), 64'd3);
            tick();
        end
        wb_valid = 1'b1; wb_idx = 4'd9; wb_data = 32'h99;
        tick(); wb_valid = 1'b0;
        drain("ord_drain");

        // Flush with 3 valid entries and a concurrent enqueue and wakeup
        ls_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_enq(16'h0300 + 16'(i), 4'(i), 32'h300, 1'b1, 4'd0, 32'h0, 1'b0, 4'd2);
            tick();
        end
        set_enq(16'h0333, 4'd7, 32'h333, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0);
        wb_valid = 1'b1; wb_idx = 4'd2; wb_data = 32'h77;
        flush = 1'b1;
        tick();
        flush = 1'b0; enq_valid = 1'b0; wb_valid = 1'b0;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_inst_valid", 64'(inst_valid), 64'd0);
        chk("fl_enq_ready", 64'(enq_ready), 64'd1);
        ls_ready = 1'b1;
        set_enq(16'h0400, 4'hE, 32'h400, 1'b1, 4'd0, 32'h401, 1'b1, 4'd0);
        sb.push_back(mk(16'h0400, 4'hE, 32'h400, 32'h401));
        tick(); enq_valid = 1'b0;
        chk("post_fl_slot", 64'(rob_slot), 64'hE);
        drain("fl_drain");

        // Asynchronous reset in the middle of filling
        ls_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_enq(16'h0500 + 16'(i), 4'(i), 32'h500, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0);
            tick();
        end
        enq_valid = 1'b0;
        chk("mid_count_pre", 64'(count), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(inst_valid), 64'd0);
        chk("mid_rst_enq_ready", 64'(enq_ready), 64'd1);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        tick();
        ls_ready = 1'b1;
        set_enq(16'h0600, 4'd5, 32'h600, 1'b1, 4'd0, 32'h601, 1'b1, 4'd0);
        sb.push_back(mk(16'h0600, 4'd5, 32'h600, 32'h601));
        tick(); enq_valid = 1'b0;
        chk("post_rst_valid", 64'(inst_valid), 64'd1);
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
